// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_wb_stage
// Brief  : Memory-access / writeback pipeline stage with load-data hold on
//          stall. Optional MEM_MISALIGN_CHECK_EN blocks misaligned accesses.
// Rev    : 1.0  initial release
// ============================================================================
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  output logic        dmem_en,
  output logic [29:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_din,
  input  logic [31:0] dmem_dout,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misaligned
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]  in_opc;
  logic        in_is_load, in_is_store, in_mis, req;
  logic [3:0]  store_mask;
  logic        unused_instr_hi;

  logic        s_valid;
  logic [6:0]  s_opc;
  logic [4:0]  s_rd;
  logic [2:0]  s_f3;
  logic [31:0] s_pc, s_alu;
  logic [31:0] hold_data;
  logic        hold_valid;
  logic        s_mis, s_is_load, s_writes_rd;
  logic [31:0] ld_word, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign in_opc          = instr[6:0];
  assign in_is_load      = (in_opc == OPC_LOAD);
  assign in_is_store     = (in_opc == OPC_STORE);
  assign unused_instr_hi = ^instr[31:15];

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic mis_fn(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [1:0] a);
    logic r;
    r = 1'b0;
    if (opc == OPC_LOAD || opc == OPC_STORE) begin
      case (f3[1:0])
        2'b01:   r = a[0];
        2'b10:   r = (a != 2'b00);
        default: r = 1'b0;
      endcase
    end
    return r;
  endfunction
  assign in_mis = mis_fn(in_opc, instr[14:12], alu_result[1:0]);
  assign s_mis  = mis_fn(s_opc, s_f3, s_alu[1:0]);
`else
  assign in_mis = 1'b0;
  assign s_mis  = 1'b0;
`endif

  assign req       = ~rst & in_valid & ~stall & ~flush & ~in_mis & (in_is_load | in_is_store);
  assign dmem_en   = req;
  assign dmem_addr = alu_result[31:2];

  // Store data is replicated across lanes so the byte mask alone selects the target.
  always_comb begin
    store_mask = 4'b0000;
    dmem_din   = rs2_data;
    case (instr[13:12])
      2'b00: begin
        store_mask = 4'b0001 << alu_result[1:0];
        dmem_din   = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        store_mask = 4'b0011 << {alu_result[1], 1'b0};
        dmem_din   = {2{rs2_data[15:0]}};
      end
      2'b10:   store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
    dmem_we = (req & in_is_store) ? store_mask : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid    <= 1'b0;
      s_opc      <= '0;
      s_rd       <= '0;
      s_f3       <= '0;
      s_pc       <= '0;
      s_alu      <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (!stall) begin
      s_valid    <= in_valid & ~flush;
      s_opc      <= instr[6:0];
      s_rd       <= instr[11:7];
      s_f3       <= instr[14:12];
      s_pc       <= pc;
      s_alu      <= alu_result;
      hold_valid <= 1'b0;
    end else if (s_valid && s_is_load && !hold_valid) begin
      // Read data is only presented for one cycle; keep it for the stall duration.
      hold_data  <= dmem_dout;
      hold_valid <= 1'b1;
    end
  end

  assign s_is_load   = (s_opc == OPC_LOAD);
  assign s_writes_rd = (s_opc == OPC_LOAD)  || (s_opc == OPC_OP)    ||
                       (s_opc == OPC_OPIMM) || (s_opc == OPC_LUI)   ||
                       (s_opc == OPC_AUIPC) || (s_opc == OPC_JAL)   ||
                       (s_opc == OPC_JALR)  || (s_opc == OPC_SYSTEM);

  assign ld_word = hold_valid ? hold_data : dmem_dout;
  assign ld_half = s_alu[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    case (s_alu[1:0])
      2'b00:   ld_byte = ld_word[7:0];
      2'b01:   ld_byte = ld_word[15:8];
      2'b10:   ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    case (s_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
    if (s_is_load)
      wb_data = ld_data;
    else if (s_opc == OPC_JAL || s_opc == OPC_JALR)
      wb_data = s_pc + 32'd4;
    else
      wb_data = s_alu;
  end

  assign wb_valid   = s_valid;
  assign wb_rd      = s_rd;
  assign wb_we      = s_valid & (s_rd != 5'd0) & s_writes_rd & ~s_mis;
  assign misaligned = s_valid & s_mis;

endmodule
`default_nettype wire
